// File: rtl/boa_mem_pkg.sv
// Shared helpers for boa_mem targets: lane/word geometry and response-state encoding.
package boa_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    function automatic int wes_of(input int dlen);
        return dlen / 8;
    endfunction

    function automatic int word_lsb(input int dlen);
        return $clog2(dlen / 8);
    endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// Word-addressed memory bus: initiator drives re/we/addr/wdata, target answers with ready/rdata.
interface boa_mem_bus #(
    parameter int alen = 32,
    parameter int dlen = 32
);
    logic                  re;
    logic [dlen/8-1:0]     we;
    logic [alen-1:2]       addr;
    logic [dlen-1:0]       wdata;
    logic                  ready;
    logic [dlen-1:0]       rdata;

    modport MEM (input re, we, addr, wdata, output ready, rdata);
    modport CPU (output re, we, addr, wdata, input ready, rdata);
endinterface

// File: rtl/boa_mem_ram_array.sv
// Byte-enable synchronous RAM, single address, read-before-write, no reset.
// Latency: read data registered one edge after en.
// Backpressure: none; caller gates en.
module boa_mem_ram_array
    import boa_mem_pkg::*;
#(
    parameter int awid = 10,
    parameter int dlen = 32
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      rd,
    input  logic [wes_of(dlen)-1:0]   we,
    input  logic [awid-1:0]           addr,
    input  logic [dlen-1:0]           wdata,
    output logic [dlen-1:0]           rdata
);
    logic [dlen-1:0] mem [2**awid];

    // Non-blocking read of mem gives the pre-write word when rd and we coincide.
    always_ff @(posedge clk) begin
        if (en) begin
            if (rd) begin
                rdata <= mem[addr];
            end
            for (int i = 0; i < wes_of(dlen); i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/boa_mem_ram.sv
// On-chip RAM target for boa_mem_bus with address decode and programmable wait states.
// Latency: 1 cycle + waits (sampled at accept).
// Backpressure: ready low while the wait counter is non-zero.
module boa_mem_ram
    import boa_mem_pkg::*;
#(
    parameter int              alen = 32,
    parameter int              dlen = 32,
    parameter logic [alen-1:0] base = '0,
    parameter int              size = 12,
    parameter int              wlen = 4
) (
    input  logic            clk,
    input  logic            rst,
    boa_mem_bus.MEM         bus,
    input  logic [wlen-1:0] waits
);
    localparam int              wes  = wes_of(dlen);
    localparam int              lsb  = word_lsb(dlen);
    localparam int              awid = size - lsb;
    localparam logic [alen-3:0] m    = {(alen-2){1'b1}} >> (alen - size);
    localparam logic [alen-3:0] bw   = base[alen-1:2];

    logic [wlen-1:0] cnt;
    logic            resp;
    logic            rd_q;
    logic            ready;
    logic            sel;
    logic            accept;
    logic [dlen-1:0] arr_rdata;
    mem_state_t      state;

    assign sel    = ((bus.addr | m) == (bw | m));
    assign ready  = (cnt == '0);
    assign accept = ready && sel && (bus.re || (bus.we != '0));

    boa_mem_ram_array #(
        .awid (awid),
        .dlen (dlen)
    ) u_array (
        .clk   (clk),
        .en    (accept),
        .rd    (bus.re),
        .we    (bus.we),
        .addr  (bus.addr[size-1:lsb]),
        .wdata (bus.wdata),
        .rdata (arr_rdata)
    );

    // The array output register holds between accepts, so it serves as rdata_q;
    // rd_q zeroes the response for write-only accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            resp <= 1'b0;
            rd_q <= 1'b0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else if (accept) begin
            cnt  <= waits;
            resp <= 1'b1;
            rd_q <= bus.re;
        end else begin
            resp <= 1'b0;
            rd_q <= 1'b0;
        end
    end

    assign bus.ready = ready;
    assign bus.rdata = (resp && ready && rd_q) ? arr_rdata : '0;

    always_comb begin
        state = ST_IDLE;
        if (!ready) begin
            state = ST_WAIT;
        end else if (resp) begin
            state = ST_RESP;
        end
    end

    a_wait_to_resp: assert property (@(posedge clk) disable iff (!rst)
        (state == ST_WAIT) |=> (state != ST_IDLE));

    logic unused_wes;
    assign unused_wes = ^{wes[0]};

endmodule

// File: tb/tb_boa_mem_ram.sv
// Scoreboard bench for boa_mem_ram: one instance at base 0, one at base 0x1000.
module tb_boa_mem_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  waits0;
    logic [3:0]  waits1;
    int          tgt;
    logic        re_d;
    logic [3:0]  we_d;
    logic [29:0] addr_d;
    logic [31:0] wdata_d;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    boa_mem_bus #(.alen(32), .dlen(32)) bus0 ();
    boa_mem_bus #(.alen(32), .dlen(32)) bus1 ();

    assign bus0.re    = (tgt == 0) ? re_d : 1'b0;
    assign bus0.we    = (tgt == 0) ? we_d : 4'h0;
    assign bus0.addr  = addr_d;
    assign bus0.wdata = wdata_d;
    assign bus1.re    = (tgt == 1) ? re_d : 1'b0;
    assign bus1.we    = (tgt == 1) ? we_d : 4'h0;
    assign bus1.addr  = addr_d;
    assign bus1.wdata = wdata_d;

    wire        rdy  = (tgt == 0) ? bus0.ready : bus1.ready;
    wire [31:0] rdat = (tgt == 0) ? bus0.rdata : bus1.rdata;

    boa_mem_ram #(.alen(32), .dlen(32), .base(32'h0000_0000), .size(12), .wlen(4)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus0),
        .waits (waits0)
    );

    boa_mem_ram #(.alen(32), .dlen(32), .base(32'h0000_1000), .size(12), .wlen(4)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus1),
        .waits (waits1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        re_d = 1'b0;
        we_d = 4'h0;
    endtask

    // Called at a negedge with ready high; returns at the completion negedge so
    // the next call is presented back-to-back.
    task automatic access(input string tag, input bit r, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input int exp_stall,
                          input logic [31:0] a_chg);
        int          stalls;
        logic [31:0] want;
        stalls  = 0;
        re_d    = r;
        we_d    = w;
        addr_d  = a[31:2];
        wdata_d = d;
        #1;
        chk({tag, "_rdy"}, 32'(rdy), 32'd1);
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        while (!rdy && stalls < 20) begin
            stalls++;
            addr_d  = a_chg[31:2];
            wdata_d = ~d;
            @(negedge clk);
        end
        chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
        want = exp_q.pop_front();
        chk({tag, "_rdata"}, rdat, want);
    endtask

    task automatic reject(input string tag, input bit r, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] d);
        re_d    = r;
        we_d    = w;
        addr_d  = a[31:2];
        wdata_d = d;
        @(negedge clk);
        idle();
        chk({tag, "_rdy"}, 32'(rdy), 32'd1);
        chk({tag, "_rdata"}, rdat, 32'h0);
    endtask

    task automatic idle_chk(input string tag);
        idle();
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(rdy), 32'd1);
        chk({tag, "_rdata"}, rdat, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        tgt     = 0;
        waits0  = 4'd0;
        waits1  = 4'd0;
        addr_d  = '0;
        wdata_d = '0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_rdy0", 32'(bus0.ready), 32'd1);
        chk("rst_rdata0", bus0.rdata, 32'h0);
        chk("rst_rdy1", 32'(bus1.ready), 32'd1);
        chk("rst_rdata1", bus1.rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back write then read, zero waits
        access("wr10", 1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 32'h10);
        access("rd10", 1'b1, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 32'h10);
        idle_chk("idle1");

        // Byte lanes
        access("wr14", 1'b0, 4'hF, 32'h14, 32'h1122_3344, 32'h0, 0, 32'h14);
        access("wr14b", 1'b0, 4'h1, 32'h14, 32'h0000_00AA, 32'h0, 0, 32'h14);
        access("rd14", 1'b1, 4'h0, 32'h14, 32'h0, 32'h1122_33AA, 0, 32'h14);

        // Wait states; address changed during the stall must be ignored
        access("wr20", 1'b0, 4'hF, 32'h20, 32'h2020_2020, 32'h0, 0, 32'h20);
        access("wr24", 1'b0, 4'hF, 32'h24, 32'h2424_2424, 32'h0, 0, 32'h24);
        waits0 = 4'd3;
        access("rd20w", 1'b1, 4'h0, 32'h20, 32'h0, 32'h2020_2020, 3, 32'h24);
        waits0 = 4'd0;
        access("rd24", 1'b1, 4'h0, 32'h24, 32'h0, 32'h2424_2424, 0, 32'h24);

        // Stalled write: one write only, to the accepted address and data
        access("wr2c", 1'b0, 4'hF, 32'h2C, 32'h2C2C_2C2C, 32'h0, 0, 32'h2C);
        waits0 = 4'd2;
        access("wr28w", 1'b0, 4'hF, 32'h28, 32'h0000_0001, 32'h0, 2, 32'h2C);
        waits0 = 4'd0;
        access("rd2c", 1'b1, 4'h0, 32'h2C, 32'h0, 32'h2C2C_2C2C, 0, 32'h2C);
        access("rd28", 1'b1, 4'h0, 32'h28, 32'h0, 32'h0000_0001, 0, 32'h28);

        // Simultaneous read and write returns the old word
        access("wr30", 1'b0, 4'hF, 32'h30, 32'h0000_0005, 32'h0, 0, 32'h30);
        access("rw30", 1'b1, 4'hF, 32'h30, 32'h0000_0009, 32'h0000_0005, 0, 32'h30);
        access("rd30", 1'b1, 4'h0, 32'h30, 32'h0, 32'h0000_0009, 0, 32'h30);

        // Reset during a stalled write
        waits0  = 4'd7;
        re_d    = 1'b0;
        we_d    = 4'hF;
        addr_d  = 30'(32'h40 >> 2);
        wdata_d = 32'hCAFE_0001;
        exp_q.push_back(32'h0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("stall_pre_rst", 32'(rdy), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_rdy", 32'(rdy), 32'd1);
        chk("rst_async_rdata", rdat, 32'h0);
        void'(exp_q.pop_front());
        idle();
        @(negedge clk);
        rst    = 1'b1;
        waits0 = 4'd0;
        @(negedge clk);
        access("rd40", 1'b1, 4'h0, 32'h40, 32'h0, 32'hCAFE_0001, 0, 32'h40);
        access("wr44", 1'b0, 4'hF, 32'h44, 32'h4444_0000, 32'h0, 0, 32'h44);
        access("rd44", 1'b1, 4'h0, 32'h44, 32'h0, 32'h4444_0000, 0, 32'h44);
        idle_chk("idle2");

        // Decode on the instance at base 0x1000
        tgt = 1;
        @(negedge clk);
        access("d_wr1ffc", 1'b0, 4'hF, 32'h1FFC, 32'hA1A1_A1A1, 32'h0, 0, 32'h1FFC);
        access("d_wr1000", 1'b0, 4'hF, 32'h1000, 32'hB1B1_B1B1, 32'h0, 0, 32'h1000);
        reject("d_nsel_0ffc", 1'b0, 4'hF, 32'h0FFC, 32'hFFFF_FFFF);
        reject("d_nsel_2000", 1'b0, 4'hF, 32'h2000, 32'hEEEE_EEEE);
        reject("d_nsel_rd", 1'b1, 4'h0, 32'h0FFC, 32'h0);
        access("d_rd1ffc", 1'b1, 4'h0, 32'h1FFC, 32'h0, 32'hA1A1_A1A1, 0, 32'h1FFC);
        access("d_rd1000", 1'b1, 4'h0, 32'h1000, 32'h0, 32'hB1B1_B1B1, 0, 32'h1000);
        idle_chk("idle3");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
